// File: rtl/eink_pkg.sv
// Shared types for the e-ink refresh sequencer: FSM state encoding, driver
// mode codes and the pass-number-to-mode mapping.
package eink_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_PULSE     = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_GAP       = 3'd5,
        ST_FINISH    = 3'd6
    } state_t;

    localparam logic [1:0] MODE_WHITE = 2'd0;
    localparam logic [1:0] MODE_DRAW  = 2'd1;
    localparam logic [1:0] MODE_BLACK = 2'd2;

    // Full updates open with white/black flash pairs; everything else is a draw.
    function automatic logic [1:0] pass_mode(input logic [7:0] idx,
                                             input logic       full,
                                             input int         flash_passes);
        if (full && (int'(idx) < 2 * flash_passes)) begin
            return idx[0] ? MODE_BLACK : MODE_WHITE;
        end
        return MODE_DRAW;
    endfunction

endpackage

// File: rtl/eink_timeout_cnt.sv
// Loadable saturating down-counter; expired is the terminal-count compare.
module eink_timeout_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/eink_update_seq.sv
// Refresh sequencer for the ed060sc7 driver: turns one host update request
// into a series of flash/draw passes, pacing each on the driver's ready.
//
// state     | meaning
// IDLE      | waiting for upd_req
// ARM       | mode set up for this pass, waiting for driver ready
// PULSE     | one-cycle start pulse
// WAIT_ACK  | waiting for ready to fall (ack timeout running)
// WAIT_DONE | waiting for ready to rise (pass timeout running)
// GAP       | inter-pass idle time
// FINISH    | done pulse, back to IDLE
module eink_update_seq
    import eink_pkg::*;
#(
    parameter int FLASH_PASSES = 2,
    parameter int DRAW_PASSES  = 4,
    parameter int GAP_CYCLES   = 16,
    parameter int ACK_TIMEOUT  = 256,
    parameter int PASS_TIMEOUT = 2**22
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       upd_req,
    input  logic       upd_full,
    input  logic       abort,
    input  logic       drv_ready,
    output logic [1:0] drv_mode,
    output logic       drv_start,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] pass_idx
);

    localparam int TOTAL_FULL = 2 * FLASH_PASSES + DRAW_PASSES;

    if (TOTAL_FULL > 255 || DRAW_PASSES < 1 || FLASH_PASSES < 0 ||
        ACK_TIMEOUT < 1 || ACK_TIMEOUT > 512 || PASS_TIMEOUT < 1 ||
        PASS_TIMEOUT > 2**23 || GAP_CYCLES < 0 || GAP_CYCLES > 256) begin : g_bad_cfg
        $error("eink_update_seq: pass count or timer parameters out of range");
    end

    localparam logic [7:0]  LAST_FULL = 8'(TOTAL_FULL - 1);
    localparam logic [7:0]  LAST_PART = 8'(DRAW_PASSES - 1);
    localparam logic [8:0]  ACK_LOAD  = 9'(ACK_TIMEOUT - 1);
    localparam logic [22:0] PASS_LOAD = 23'(PASS_TIMEOUT - 1);
    localparam logic [7:0]  GAP_LOAD  = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit          HAS_GAP   = (GAP_CYCLES > 0);

    state_t     state_q, state_d;
    logic       full_q, full_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       start_q, start_d;
    logic       abort_q, abort_d;
    logic [1:0] mode_q, mode_d;
    logic [7:0] pass_idx_q, pass_idx_d;

    logic ack_exp, pass_exp, gap_exp;
    logic abort_now, last_pass;

    eink_timeout_cnt #(.W(9)) u_ack_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (state_q == ST_PULSE),
        .load_val (ACK_LOAD),
        .dec      (state_q == ST_WAIT_ACK),
        .expired  (ack_exp)
    );

    eink_timeout_cnt #(.W(23)) u_pass_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (state_q == ST_WAIT_ACK),
        .load_val (PASS_LOAD),
        .dec      (state_q == ST_WAIT_DONE),
        .expired  (pass_exp)
    );

    eink_timeout_cnt #(.W(8)) u_gap_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (state_q == ST_WAIT_DONE),
        .load_val (GAP_LOAD),
        .dec      (state_q == ST_GAP),
        .expired  (gap_exp)
    );

    assign abort_now = abort_q | abort;
    assign last_pass = (pass_idx_q == (full_q ? LAST_FULL : LAST_PART));

    always_comb begin
        state_d    = state_q;
        full_d     = full_q;
        err_d      = err_q;
        busy_d     = busy_q;
        pass_idx_d = pass_idx_q;
        abort_d    = abort_q | (busy_q & abort);

        case (state_q)
            ST_IDLE: begin
                if (upd_req) begin
                    full_d     = upd_full;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                    pass_idx_d = 8'd0;
                    state_d    = ST_ARM;
                end
            end
            ST_ARM: begin
                if (abort_now) begin
                    state_d = ST_FINISH;
                end else if (drv_ready) begin
                    state_d = ST_PULSE;
                end
            end
            ST_PULSE: state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (!drv_ready) begin
                    state_d = ST_WAIT_DONE;
                end else if (ack_exp) begin
                    err_d   = 1'b1;
                    state_d = ST_FINISH;
                end
            end
            ST_WAIT_DONE: begin
                if (drv_ready) begin
                    if (last_pass || abort_now) begin
                        state_d = ST_FINISH;
                    end else begin
                        pass_idx_d = pass_idx_q + 8'd1;
                        state_d    = HAS_GAP ? ST_GAP : ST_ARM;
                    end
                end else if (pass_exp) begin
                    err_d   = 1'b1;
                    state_d = ST_FINISH;
                end
            end
            ST_GAP: begin
                if (abort_now) begin
                    state_d = ST_FINISH;
                end else if (gap_exp) begin
                    state_d = ST_ARM;
                end
            end
            ST_FINISH: begin
                abort_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_FINISH) begin
            busy_d = 1'b0;
        end
        start_d = (state_d == ST_PULSE);
        done_d  = (state_d == ST_FINISH);
        // Mode is updated on entry to ARM so it is stable a full cycle before start.
        mode_d  = (state_d == ST_ARM) ? pass_mode(pass_idx_d, full_d, FLASH_PASSES) : mode_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            full_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            start_q    <= 1'b0;
            abort_q    <= 1'b0;
            mode_q     <= MODE_WHITE;
            pass_idx_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            full_q     <= full_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            start_q    <= start_d;
            abort_q    <= abort_d;
            mode_q     <= mode_d;
            pass_idx_q <= pass_idx_d;
        end
    end

    assign drv_mode  = mode_q;
    assign drv_start = start_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign pass_idx  = pass_idx_q;

endmodule
